// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, bit positions.
package cp0_pkg;

   // CP0 register numbers (rd field of MFC0/MTC0)
   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_STATUS  = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;

   // Cause.ExcCode values
   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_SYS = 5'd8;
   localparam logic [4:0] EXC_RI  = 5'd10;

   // Status / Cause field positions
   localparam int ST_IE    = 0;
   localparam int ST_EXL   = 1;
   localparam int ST_IM_LO = 10;
   localparam int CA_IP_LO = 10;
   localparam int CA_EXC_LO = 2;
   localparam int IRQ_BITS = 6;

   // Handler entry address loaded by the PC on hasExp
   localparam logic [31:0] EXC_VECTOR = 32'h0000_0800;

endpackage

// File: rtl/cp0_unit_irq_sync.sv
// Two-flop synchroniser for asynchronous level interrupt requests.
module irq_sync #(
   parameter int WIDTH = 1
) (
   input  logic             gated_clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   // shift the raw level through two stages
   always_comb begin
      meta_d = din;
      sync_d = meta_q;
   end

   // synchroniser flops, cleared by reset
   always_ff @(posedge gated_clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign dout = sync_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0: exception/interrupt detection, EPC/Cause/Status,
// Count/Compare timer and MFC0/MTC0 access for the single-cycle CPU.
module cp0_unit #(
   parameter logic [31:0] EXC_VECTOR  = cp0_pkg::EXC_VECTOR,
   parameter int          NUM_EXT_IRQ = 5
) (
   input  logic                   gated_clk,
   input  logic                   rst,
   input  logic [31:0]            pc,
   input  logic                   isCOP0,
   input  logic                   isEret,
   input  logic                   isMfc0,
   input  logic                   isMtc0,
   input  logic [4:0]             cp0_reg,
   input  logic [31:0]            wdata,
   output logic [31:0]            rdata,
   input  logic                   syscall,
   input  logic                   illegal_instr,
   input  logic [NUM_EXT_IRQ-1:0] ext_irq,
   output logic                   hasExp,
   output logic [31:0]            cp0_target_addr
);
   import cp0_pkg::*;

   logic                   ie_q, ie_d, exl_q, exl_d;
   logic [IRQ_BITS-1:0]    im_q, im_d;
   logic [4:0]             exccode_q, exccode_d;
   logic [31:0]            epc_q, epc_d, count_q, count_d, compare_q, compare_d;
   logic                   timer_pend_q, timer_pend_d;
   logic [NUM_EXT_IRQ-1:0] irq_synced;
   logic [IRQ_BITS-2:0]    ext_ip;
   logic [IRQ_BITS-1:0]    ip;
   logic                   irq_take, do_eret, do_mtc0;
   logic [4:0]             exc_sel;
   logic [31:0]            status_rd, cause_rd;

   // The vector is consumed by the PC; kept here only as a reference value.
   logic unused_vector;
   assign unused_vector = ^EXC_VECTOR;

   irq_sync #(.WIDTH(NUM_EXT_IRQ)) u_irq_sync (
      .gated_clk (gated_clk),
      .rst       (rst),
      .din       (ext_irq),
      .dout      (irq_synced)
   );

   // live pending bits: timer on top, external lines below
   always_comb begin
      ext_ip = '0;
      ext_ip[NUM_EXT_IRQ-1:0] = irq_synced;
      ip = {timer_pend_q, ext_ip};
   end

   // exception detection and priority: irq, then illegal, then syscall
   always_comb begin
      irq_take = ie_q & ~exl_q & (|(ip & im_q));
      hasExp   = ~rst & (irq_take | illegal_instr | syscall);
      if (irq_take)           exc_sel = EXC_INT;
      else if (illegal_instr) exc_sel = EXC_RI;
      else                    exc_sel = EXC_SYS;
      do_eret = isCOP0 & isEret & ~hasExp;
      do_mtc0 = isCOP0 & isMtc0 & ~hasExp;
   end

   // next-state: exception entry suppresses the current instruction
   always_comb begin
      ie_d         = ie_q;
      exl_d        = exl_q;
      im_d         = im_q;
      exccode_d    = exccode_q;
      epc_d        = epc_q;
      compare_d    = compare_q;
      count_d      = count_q + 32'd1;
      timer_pend_d = timer_pend_q | (count_q == compare_q);
      if (hasExp) begin
         epc_d     = pc;
         exl_d     = 1'b1;
         exccode_d = exc_sel;
      end else begin
         if (do_eret) exl_d = 1'b0;
         if (do_mtc0) begin
            case (cp0_reg)
               REG_STATUS: begin
                  ie_d  = wdata[ST_IE];
                  exl_d = wdata[ST_EXL];
                  im_d  = wdata[ST_IM_LO +: IRQ_BITS];
               end
               REG_EPC:     epc_d = wdata;
               REG_COUNT:   count_d = wdata;
               REG_COMPARE: begin
                  compare_d    = wdata;
                  timer_pend_d = 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   // CP0 state registers
   always_ff @(posedge gated_clk or posedge rst) begin
      if (rst) begin
         ie_q         <= 1'b0;
         exl_q        <= 1'b0;
         im_q         <= '0;
         exccode_q    <= '0;
         epc_q        <= '0;
         count_q      <= '0;
         compare_q    <= '1;
         timer_pend_q <= 1'b0;
      end else begin
         ie_q         <= ie_d;
         exl_q        <= exl_d;
         im_q         <= im_d;
         exccode_q    <= exccode_d;
         epc_q        <= epc_d;
         count_q      <= count_d;
         compare_q    <= compare_d;
         timer_pend_q <= timer_pend_d;
      end
   end

   // MFC0 read mux; unimplemented registers read 0
   always_comb begin
      status_rd = '0;
      status_rd[ST_IE]  = ie_q;
      status_rd[ST_EXL] = exl_q;
      status_rd[ST_IM_LO +: IRQ_BITS] = im_q;
      cause_rd = '0;
      cause_rd[CA_IP_LO +: IRQ_BITS] = ip;
      cause_rd[CA_EXC_LO +: 5] = exccode_q;
      rdata = '0;
      if (isCOP0 & isMfc0) begin
         case (cp0_reg)
            REG_COUNT:   rdata = count_q;
            REG_COMPARE: rdata = compare_q;
            REG_STATUS:  rdata = status_rd;
            REG_CAUSE:   rdata = cause_rd;
            REG_EPC:     rdata = epc_q;
            default:     rdata = '0;
         endcase
      end
   end

   assign cp0_target_addr = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the CP0 rules.
module tb_cp0_unit;
   import cp0_pkg::*;

   logic        gated_clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc = '0, wdata = '0;
   logic        isCOP0 = 0, isEret = 0, isMfc0 = 0, isMtc0 = 0;
   logic [4:0]  cp0_reg = '0;
   logic        syscall = 0, illegal_instr = 0;
   logic [4:0]  ext_irq = '0;
   logic [31:0] rdata, cp0_target_addr;
   logic        hasExp;

   cp0_unit #(.EXC_VECTOR(32'h0000_0800), .NUM_EXT_IRQ(5)) dut (
      .gated_clk(gated_clk), .rst(rst), .pc(pc), .isCOP0(isCOP0),
      .isEret(isEret), .isMfc0(isMfc0), .isMtc0(isMtc0), .cp0_reg(cp0_reg),
      .wdata(wdata), .rdata(rdata), .syscall(syscall),
      .illegal_instr(illegal_instr), .ext_irq(ext_irq), .hasExp(hasExp),
      .cp0_target_addr(cp0_target_addr)
   );

   always #5 gated_clk = ~gated_clk;

   int n_assert = 0, n_fail = 0;

   // behavioural model state
   logic        m_ie, m_exl, m_tp;
   logic [5:0]  m_im;
   logic [4:0]  m_exc, m_s1, m_s2;
   logic [31:0] m_epc, m_count, m_cmp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_ie = 0; m_exl = 0; m_tp = 0; m_im = 0; m_exc = 0;
      m_s1 = 0; m_s2 = 0; m_epc = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
   endtask

   function automatic logic m_irq();
      return m_ie && !m_exl && (({m_tp, m_s2} & m_im) != 0);
   endfunction

   function automatic logic m_has();
      return !rst && (m_irq() || illegal_instr || syscall);
   endfunction

   function automatic logic [4:0] m_code();
      return m_irq() ? 5'd0 : (illegal_instr ? 5'd10 : 5'd8);
   endfunction

   function automatic logic [31:0] m_rdata();
      if (!(isCOP0 && isMfc0)) return 0;
      case (cp0_reg)
         5'd9:  return m_count;
         5'd11: return m_cmp;
         5'd12: return 32'(m_ie) + 32'(m_exl) * 2 + 32'(m_im) * 1024;
         5'd13: return 32'({m_tp, m_s2}) * 1024 + 32'(m_exc) * 4;
         5'd14: return m_epc;
         default: return 0;
      endcase
   endfunction

   // apply one clock edge's worth of CP0 rules to the model
   task automatic m_edge();
      logic [31:0] cnt_n;
      logic        tp_n, has;
      logic [4:0]  code;
      has = m_has(); code = m_code();
      cnt_n = m_count + 1;
      tp_n = m_tp || (m_count == m_cmp);
      if (has) begin
         m_epc = pc; m_exl = 1; m_exc = code;
      end else if (isCOP0) begin
         if (isEret) m_exl = 0;
         if (isMtc0) begin
            case (cp0_reg)
               5'd9:  cnt_n = wdata;
               5'd11: begin m_cmp = wdata; tp_n = 0; end
               5'd12: begin m_ie = wdata[0]; m_exl = wdata[1]; m_im = wdata[15:10]; end
               5'd14: m_epc = wdata;
               default: ;
            endcase
         end
      end
      m_count = cnt_n; m_tp = tp_n;
      m_s2 = m_s1; m_s1 = ext_irq;
   endtask

   // check outputs against the model, then take one edge
   task automatic cyc();
      #1;
      chk("hasExp", 32'(hasExp), 32'(m_has()));
      chk("target", cp0_target_addr, m_epc);
      chk("rdata", rdata, m_rdata());
      @(posedge gated_clk);
      m_edge();
      #1;
   endtask

   task automatic idle();
      isCOP0 = 0; isEret = 0; isMfc0 = 0; isMtc0 = 0; cp0_reg = 0;
      wdata = 0; syscall = 0; illegal_instr = 0;
   endtask

   task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
      idle(); isCOP0 = 1; isMtc0 = 1; cp0_reg = r; wdata = d; cyc();
   endtask

   task automatic rd(input logic [4:0] r, output logic [31:0] v, output logic h);
      idle(); isCOP0 = 1; isMfc0 = 1; cp0_reg = r; #1; v = rdata; h = hasExp; cyc();
   endtask

   logic [31:0] v;
   logic        h;
   logic [4:0]  regs [6];
   int          op;

   initial begin
      regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
      // reset state, with a syscall held to show hasExp is forced low
      m_reset(); syscall = 1; #1;
      chk("rst_hasExp", 32'(hasExp), 0);
      chk("rst_target", cp0_target_addr, 0);
      chk("rst_rdata", rdata, 0);
      @(posedge gated_clk); #1; rst = 0; idle();

      // syscall entry and ERET return
      pc = 32'h100; syscall = 1; #1;
      chk("sys_hasExp", 32'(hasExp), 1);
      cyc();
      rd(REG_EPC, v, h);    chk("sys_epc", v, 32'h100);
      rd(REG_CAUSE, v, h);  chk("sys_exc", 32'(v[6:2]), 8);
      rd(REG_STATUS, v, h); chk("sys_exl", 32'(v[1]), 1);
      idle(); isCOP0 = 1; isEret = 1; #1;
      chk("eret_target", cp0_target_addr, 32'h100);
      cyc();
      rd(REG_STATUS, v, h); chk("eret_exl", 32'(v[1]), 0);

      // enabled interrupt: visible on the 2nd cycle after assertion
      mtc0(REG_STATUS, 32'h0000_0401);
      idle(); ext_irq = 5'b00001; #1;
      chk("irq_c0", 32'(hasExp), 0);
      cyc(); chk("irq_c1", 32'(hasExp), 0);
      cyc(); chk("irq_c2", 32'(hasExp), 1);
      cyc();
      rd(REG_CAUSE, v, h); chk("irq_exc", 32'(v[6:2]), 0);
      // masked: IM=0 keeps hasExp low while the IP bit still shows
      mtc0(REG_STATUS, 32'h0000_0001);
      rd(REG_CAUSE, v, h);
      chk("mask_hasExp", 32'(h), 0);
      chk("mask_ip10", 32'(v[10]), 1);
      ext_irq = 0;

      // priority: illegal over syscall, interrupt over both
      idle(); illegal_instr = 1; syscall = 1; cyc();
      rd(REG_CAUSE, v, h); chk("prio_ri", 32'(v[6:2]), 10);
      mtc0(REG_STATUS, 32'h0000_0401);
      idle(); ext_irq = 5'b00001; cyc(); cyc();
      illegal_instr = 1; syscall = 1; #1;
      chk("prio_has", 32'(hasExp), 1);
      cyc();
      rd(REG_CAUSE, v, h); chk("prio_int", 32'(v[6:2]), 0);
      ext_irq = 0;
      mtc0(REG_STATUS, 0);
      idle(); cyc(); cyc();

      // timer: Count=5, Compare=8, IE=1, IM[15]=1
      mtc0(REG_COUNT, 5);
      mtc0(REG_COMPARE, 8);
      mtc0(REG_STATUS, 32'h0000_8001);
      idle(); cyc();
      idle(); isCOP0 = 1; isMfc0 = 1; cp0_reg = REG_COUNT; #1;
      chk("tmr_pre_has", 32'(hasExp), 0);
      cyc();
      idle(); isCOP0 = 1; isMfc0 = 1; cp0_reg = REG_COUNT; #1;
      chk("tmr_count9", rdata, 9);
      chk("tmr_has", 32'(hasExp), 1);
      cyc();
      rd(REG_CAUSE, v, h); chk("tmr_ip15", 32'(v[15]), 1);
      mtc0(REG_COMPARE, 32'h0000_1000);
      rd(REG_CAUSE, v, h); chk("tmr_clr15", 32'(v[15]), 0);
      mtc0(REG_STATUS, 0);

      // suppression: MTC0 EPC under an exception loses to pc
      idle(); pc = 32'h300; isCOP0 = 1; isMtc0 = 1; cp0_reg = REG_EPC;
      wdata = 32'h200; illegal_instr = 1; cyc();
      rd(REG_EPC, v, h); chk("supp_epc", v, 32'h300);

      // async reset mid-handler (EXL=1, Count nonzero)
      idle(); syscall = 1; #2; rst = 1; #1;
      chk("arst_hasExp", 32'(hasExp), 0);
      chk("arst_target", cp0_target_addr, 0);
      syscall = 0; isCOP0 = 1; isMfc0 = 1;
      cp0_reg = REG_STATUS;  #1; chk("arst_status", rdata, 0);
      cp0_reg = REG_COUNT;   #1; chk("arst_count", rdata, 0);
      cp0_reg = REG_EPC;     #1; chk("arst_epc", rdata, 0);
      cp0_reg = REG_CAUSE;   #1; chk("arst_cause", rdata, 0);
      cp0_reg = REG_COMPARE; #1; chk("arst_compare", rdata, 32'hFFFF_FFFF);
      m_reset(); idle();
      @(posedge gated_clk); #1; rst = 0;

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         idle();
         pc = $urandom & 32'hFFFF_FFFC;
         op = $urandom_range(0, 11);
         case (op)
            0, 1, 2: begin isCOP0 = 1; isMfc0 = 1; cp0_reg = regs[$urandom_range(0, 5)]; end
            3, 4: begin
               isCOP0 = 1; isMtc0 = 1; cp0_reg = regs[$urandom_range(0, 5)];
               wdata = $urandom;
               if (cp0_reg == REG_COMPARE && $urandom_range(0, 1) == 1)
                  wdata = m_count + $urandom_range(1, 4);
            end
            5: begin isCOP0 = 1; isEret = 1; end
            6: syscall = ($urandom_range(0, 2) == 0);
            7: illegal_instr = ($urandom_range(0, 2) == 0);
            8: begin isMfc0 = 1; isEret = $urandom_range(0, 1) == 1; cp0_reg = regs[$urandom_range(0, 4)]; end
            default: ;
         endcase
         if ($urandom_range(0, 7) == 0) ext_irq = 5'($urandom);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 control block for the single-cycle CPU, and the responder side of the PC's exception/return interface. It detects exceptions and interrupts and drives `hasExp` to the PC. It records EPC, Cause and Status, and supplies `cp0_target_addr` when ERET executes. It also implements MFC0/MTC0 access, a Count/Compare timer, and synchronisation of external interrupt lines.

## Interface
- `EXC_VECTOR`, default 32'h0000_0800: handler entry address the PC loads; exported for software/bench reference only.
- `NUM_EXT_IRQ`, default 5: external interrupt lines, mapped to Cause.IP[14:10].
- `gated_clk` in 1: clock, the same gated clock that drives the PC register.
- `rst` in 1: reset, asynchronous, active-high.
- `pc` in 32: address of the current instruction.
- `isCOP0` in 1: current instruction is a COP0-class instruction.
- `isEret` in 1: ERET decode; acts only when `isCOP0`=1.
- `isMfc0` in 1: MFC0 decode; qualified by `isCOP0`.
- `isMtc0` in 1: MTC0 decode; qualified by `isCOP0`.
- `cp0_reg` in 5: CP0 register number (rd field).
- `wdata` in 32: MTC0 write data (rt value).
- `rdata` out 32: MFC0 read data, combinational.
- `syscall` in 1: SYSCALL decoded.
- `illegal_instr` in 1: reserved or undefined opcode decoded.
- `ext_irq` in NUM_EXT_IRQ: asynchronous level interrupt requests.
- `hasExp` out 1: take an exception this cycle, combinational.
- `cp0_target_addr` out 32: ERET target, always equal to EPC.

## Operation
- **Registers:**
  - Status(12): bit0 IE, bit1 EXL, [15:10] IM; all other bits read 0.
  - Cause(13): [15:10] IP, read-only live pending bits; [6:2] ExcCode; read-only to software.
  - EPC(14): 32-bit read/write register.
  - Count(9): 32-bit read/write counter.
  - Compare(11): 32-bit read/write register.
  - Unimplemented register numbers read 0 and ignore writes.
- **Pending interrupts:**
  - IP[14:10] = synchronised `ext_irq`.
  - IP[15] = `timer_pend`.
- **Interrupt condition:** `irq_take` = IE & ~EXL & |(IP & IM).
- **`hasExp` priority:**
  - `irq_take` first, ExcCode 0.
  - Then `illegal_instr`, ExcCode 10.
  - Then `syscall`, ExcCode 8.
  - Sync exceptions are taken regardless of IE/EXL (nested entry overwrites EPC).
  - `hasExp` is forced to 0 while `rst`=1.
- **On an edge with `hasExp`=1:**
  - EPC <= `pc`, EXL <= 1, ExcCode <= selected code.
  - The current instruction is suppressed: a same-cycle MTC0 or ERET has no effect.
  - Software adds 4 to EPC after a syscall.
- **ERET** (`isCOP0` & `isEret` & ~`hasExp`):
  - EXL <= 0 at the edge.
  - `cp0_target_addr` = EPC in the same cycle.
  - ERET with EXL already 0 is legal; EXL stays 0.
- **MTC0** (`isCOP0` & `isMtc0` & ~`hasExp`) writes only writable bits.
  - Writing Compare clears `timer_pend`.
  - A Count write takes precedence over the increment.
- **Timer:**
  - Count increments by 1 on every edge, wrapping from 32'hFFFF_FFFF to 0.
  - `timer_pend` <= 1 on the edge where the pre-increment Count == Compare.
  - Clearing by a Compare write wins over a same-edge set.
- **MFC0:** `rdata` = selected register when `isCOP0` & `isMfc0`, else 0.
- **Reset values:**
  - Status, Cause, EPC, Count: 0.
  - Compare: 32'hFFFF_FFFF.
  - `timer_pend` and synchroniser flops: 0.
  - Outputs: `hasExp`=0, `cp0_target_addr`=0, `rdata`=0.

## Timing
- All state updates on posedge `gated_clk`; reset is asynchronous and takes effect immediately.
- `hasExp`, `cp0_target_addr` and `rdata` are combinational, valid in the same cycle as their inputs; the PC samples them at the same edge.
- `ext_irq` to IP latency: 2 edges through the synchroniser. `hasExp` is asserted in the cycle IP becomes visible if unmasked.
- Compare match to `hasExp`:
  - `timer_pend` is set on the edge after Count==Compare is observed.
  - `hasExp` follows in that next cycle if the interrupt is enabled.
- Reset mid-handler: EXL is cleared and EPC is lost; there is no recovery.

## Structure
- Shared package `cp0_pkg` holds:
  - Register numbers (9, 11, 12, 13, 14).
  - ExcCodes (INT=0, SYS=8, RI=10).
  - Status/Cause bit positions.
  - `EXC_VECTOR` constant.
- Sub-module `irq_sync`: 2-flop synchroniser, parameterised width, reset to 0, instanced once for `ext_irq`.

## Test plan
- **Syscall entry/return:** reset, `pc`=0x100, `syscall`=1.
  - Same cycle: `hasExp`=1.
  - After the edge: EPC=0x100, Cause.ExcCode=8, EXL=1.
  - Then ERET: `cp0_target_addr`=0x100, EXL=0 after the edge.
- **Masked vs. enabled interrupt:**
  - MTC0 Status=0x0000_0401 (IE=1, IM[10]=1), `ext_irq`[0]=1.
  - `hasExp`=1 on the 2nd cycle after assertion, ExcCode=0.
  - With IM=0: `hasExp` stays 0 and MFC0 Cause shows bit10=1.
- **Priority:** `illegal_instr`=1 and `syscall`=1 together gives ExcCode=10. With an enabled irq also pending, ExcCode=0.
- **Timer:** MTC0 Count=5, Compare=8, IE=1, IM[15]=1.
  - `hasExp` asserts once Count has reached 9.
  - MTC0 Compare clears Cause bit15 at that edge.
- **Suppression:** MTC0 EPC=0x200 in the same cycle as `illegal_instr` gives EPC=`pc`, not 0x200.
- **Async reset:** assert `rst` while EXL=1 and Count nonzero.
  - Immediately: `hasExp`=0 and all registers at their reset values.
  - MFC0 Compare returns 0xFFFF_FFFF.
